// File: rtl/miriscv_irq_ctrl.sv
// miriscv fixed-priority interrupt controller: arbitration, ack/mret tracking.
// Define MIRISCV_IRQ_EDGE_EN for edge-triggered pending bits (default: level).
module miriscv_irq_ctrl #(
  parameter int N_IRQ        = 16,
  parameter int CAUSE_OFFSET = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_IRQ-1:0] irq_i,
  input  logic [N_IRQ-1:0] mie_i,
  input  logic             irq_ack_i,
  input  logic             irq_mret_i,
  output logic             irq_o,
  output logic [31:0]      mcause_o,
  output logic [N_IRQ-1:0] irq_fin_o
);

  localparam int IW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             irq_q, irq_d;
  logic [31:0]      mcause_q, mcause_d;
  logic [N_IRQ-1:0] fin_q, fin_d;
  logic [N_IRQ-1:0] pend_q, pend_d;

  logic [N_IRQ-1:0] elig;
  logic             win_vld;
  logic [IW-1:0]    win_idx;
  logic [30:0]      win_code;
  logic [N_IRQ-1:0] idx_oh;
  logic             idx_en;

  assign elig = pend_q & mie_i;

  // Scan from the top so the lowest set index is the one left standing.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (elig[i]) begin
        win_vld = 1'b1;
        win_idx = IW'(i);
      end
    end
  end

  assign win_code = 31'(CAUSE_OFFSET) + 31'(win_idx);

  always_comb begin
    idx_oh = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      idx_oh[i] = (idx_q == IW'(i));
    end
  end

  assign idx_en = |(mie_i & idx_oh);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    irq_d    = irq_q;
    mcause_d = mcause_q;
    fin_d    = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          idx_d    = win_idx;
          mcause_d = {1'b1, win_code};
          irq_d    = 1'b1;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        // Ack wins over a mask drop in the same cycle.
        if (irq_ack_i) begin
          irq_d   = 1'b0;
          state_d = ST_SERVICE;
        end else if (!idx_en) begin
          irq_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (irq_mret_i) begin
          fin_d   = idx_oh;
          state_d = ST_IDLE;
        end
      end
      default: begin
        irq_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef MIRISCV_IRQ_EDGE_EN
  logic [N_IRQ-1:0] hist_q;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] pend_clr;

  assign rise     = irq_i & ~hist_q;
  assign pend_clr = (state_q == ST_REQ && irq_ack_i) ? idx_oh : '0;

  // A fresh edge on the line being cleared must survive.
  always_comb begin
    pend_d = (pend_q & ~pend_clr) | rise;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hist_q <= '0;
    end else begin
      hist_q <= irq_i;
    end
  end
`else
  always_comb begin
    pend_d = irq_i;
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      irq_q    <= 1'b0;
      mcause_q <= '0;
      fin_q    <= '0;
      pend_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      irq_q    <= irq_d;
      mcause_q <= mcause_d;
      fin_q    <= fin_d;
      pend_q   <= pend_d;
    end
  end

  assign irq_o     = irq_q;
  assign mcause_o  = mcause_q;
  assign irq_fin_o = fin_q;

endmodule

// File: tb/tb_miriscv_irq_ctrl.sv
// Randomised and directed bench for miriscv_irq_ctrl against a
// transaction-level model of pending lines and the current trap.
module tb_miriscv_irq_ctrl;

  localparam int N   = 16;
  localparam int OFF = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] irq = '0;
  logic [N-1:0] mie = '0;
  logic         ack = 1'b0;
  logic         mret = 1'b0;
  logic         irq_o;
  logic [31:0]  mcause;
  logic [N-1:0] fin;

  int vectors = 0;
  int miscompares = 0;

  miriscv_irq_ctrl #(.N_IRQ(N), .CAUSE_OFFSET(OFF)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .irq_i(irq),
    .mie_i(mie),
    .irq_ack_i(ack),
    .irq_mret_i(mret),
    .irq_o(irq_o),
    .mcause_o(mcause),
    .irq_fin_o(fin)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: a set of pending lines plus one optional trap in flight.
  bit           m_valid = 1'b0;
  bit           m_active = 1'b0;
  bit           m_acked = 1'b0;
  int           m_line = 0;
  logic [N-1:0] m_pend = '0;
  logic [N-1:0] m_prev = '0;
  logic         e_irq = 1'b0;
  logic [31:0]  e_cause = '0;
  logic [N-1:0] e_fin = '0;

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  always begin
    logic [N-1:0] clr;
    logic [N-1:0] elig;
    int w;
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b1;
      m_active = 1'b0;
      m_acked = 1'b0;
      m_pend = '0;
      m_prev = '0;
      e_irq = 1'b0;
      e_cause = '0;
      e_fin = '0;
    end else begin
      clr = '0;
      e_fin = '0;
      elig = m_pend & mie;
      if (!m_active) begin
        w = lowest(elig);
        if (w >= 0) begin
          m_active = 1'b1;
          m_acked = 1'b0;
          m_line = w;
          e_irq = 1'b1;
          e_cause = 32'h8000_0000 + 32'(OFF + w);
        end
      end else if (!m_acked) begin
        if (ack) begin
          m_acked = 1'b1;
          e_irq = 1'b0;
          clr[m_line] = 1'b1;
        end else if (!mie[m_line]) begin
          m_active = 1'b0;
          e_irq = 1'b0;
        end
      end else if (mret) begin
        e_fin[m_line] = 1'b1;
        m_active = 1'b0;
      end
`ifdef MIRISCV_IRQ_EDGE_EN
      m_pend = (m_pend & ~clr) | (irq & ~m_prev);
      m_prev = irq;
`else
      m_pend = irq;
`endif
    end
    #1;
    if (m_valid) begin
      chk("model_irq_o", 32'(irq_o), 32'(e_irq));
      chk("model_mcause", mcause, e_cause);
      chk("model_fin", 32'(fin), 32'(e_fin));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
  endtask

  task automatic pulse_mret();
    mret = 1'b1;
    cyc(1);
    mret = 1'b0;
  endtask

  task automatic drain();
    repeat (40) begin
      if (irq_o) begin
        pulse_ack();
        pulse_mret();
      end else begin
        cyc(1);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    irq = '1;
    cyc(1);
    chk("rst_irq_o", 32'(irq_o), 32'd0);
    chk("rst_mcause", mcause, 32'd0);
    chk("rst_fin", 32'(fin), 32'd0);
    cyc(1);
    chk("rst_irq_o2", 32'(irq_o), 32'd0);
    rst = 1'b0;
    irq = '0;
    mie = '1;
    cyc(3);

    irq[3] = 1'b1;
    cyc(1);
    chk("single_lat1", 32'(irq_o), 32'd0);
    cyc(1);
    chk("single_irq", 32'(irq_o), 32'd1);
    chk("single_cause", mcause, 32'h8000_0013);
    pulse_ack();
    chk("single_ack", 32'(irq_o), 32'd0);
    irq = '0;
    cyc(1);
    pulse_mret();
    chk("single_fin", 32'(fin), 32'h0008);
    cyc(1);
    chk("single_fin_end", 32'(fin), 32'h0000);
    drain();

    irq[5] = 1'b1;
    irq[9] = 1'b1;
    cyc(2);
    chk("prio_cause", mcause, 32'h8000_0015);
    irq[0] = 1'b1;
    cyc(2);
    chk("noprempt_cause", mcause, 32'h8000_0015);
    pulse_ack();
    pulse_mret();
    chk("prio_fin", 32'(fin), 32'h0020);
    cyc(1);
    chk("prio_next_irq", 32'(irq_o), 32'd1);
    chk("prio_next_cause", mcause, 32'h8000_0010);
    irq = '0;
    drain();

    irq[2] = 1'b1;
    cyc(2);
    chk("wd_irq", 32'(irq_o), 32'd1);
    chk("wd_cause", mcause, 32'h8000_0012);
    mie[2] = 1'b0;
    cyc(1);
    chk("wd_drop", 32'(irq_o), 32'd0);
    chk("wd_nofin", 32'(fin), 32'd0);
    mie[2] = 1'b1;
    cyc(2);
    chk("wd_again", 32'(irq_o), 32'd1);
    pulse_ack();
    irq = '0;
    pulse_mret();
    drain();

`ifdef MIRISCV_IRQ_EDGE_EN
    irq[1] = 1'b1;
    cyc(1);
    irq[1] = 1'b0;
    cyc(1);
    chk("edge_irq", 32'(irq_o), 32'd1);
    chk("edge_cause", mcause, 32'h8000_0011);
    pulse_ack();
    irq[1] = 1'b1;
    cyc(1);
    irq[1] = 1'b0;
    pulse_mret();
    chk("edge_fin", 32'(fin), 32'h0002);
    cyc(1);
    chk("edge_repres", 32'(irq_o), 32'd1);
    pulse_ack();
    pulse_mret();
    irq[1] = 1'b1;
    cyc(2);
    chk("edge_hold_irq", 32'(irq_o), 32'd1);
    pulse_ack();
    pulse_mret();
    cyc(3);
    chk("edge_hold_once", 32'(irq_o), 32'd0);
`else
    irq[1] = 1'b1;
    cyc(2);
    chk("lvl_irq", 32'(irq_o), 32'd1);
    pulse_ack();
    pulse_mret();
    chk("lvl_fin", 32'(fin), 32'h0002);
    cyc(1);
    chk("lvl_repres", 32'(irq_o), 32'd1);
`endif
    irq = '0;
    drain();

    irq[4] = 1'b1;
    cyc(2);
    chk("rstsvc_irq", 32'(irq_o), 32'd1);
    pulse_ack();
    irq = '0;
    rst = 1'b1;
    cyc(1);
    chk("rstsvc_fin", 32'(fin), 32'd0);
    chk("rstsvc_cause", mcause, 32'd0);
    rst = 1'b0;
    pulse_mret();
    chk("rstsvc_mret_fin", 32'(fin), 32'd0);
    cyc(1);
    chk("rstsvc_idle", 32'(irq_o), 32'd0);

    for (int k = 0; k < 4000; k++) begin
      int j;
      if ($urandom_range(0, 7) == 0) begin
        j = $urandom_range(0, N - 1);
        irq[j] = ~irq[j];
      end
      if ($urandom_range(0, 49) == 0) mie = N'($urandom | $urandom);
      ack  = irq_o ? ($urandom_range(0, 2) == 0)
                   : ($urandom_range(0, 19) == 0);
      mret = ($urandom_range(0, 5) == 0);
      rst  = ($urandom_range(0, 599) == 0);
      cyc(1);
    end
    rst = 1'b0;
    ack = 1'b0;
    mret = 1'b0;
    cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
